wb_arb_stage: RTL and testbench



---
 rtl/mycpu_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/wb_arb_stage.sv | 117 +++++++++++
 tb/tb_wb_arb_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared widths and field offsets for the producer-to-WB result bus
package mycpu_pkg;

  // Result bus packing, MSB first: {we, dest, result, pc}
  function automatic int bus_w(input int addr_w, input int data_w, input int pc_w);
    return 1 + addr_w + data_w + pc_w;
  endfunction

  function automatic int pc_lsb();
    return 0;
  endfunction

  function automatic int result_lsb(input int pc_w);
    return pc_w;
  endfunction

  function automatic int dest_lsb(input int data_w, input int pc_w);
    return pc_w + data_w;
  endfunction

  function automatic int we_bit(input int addr_w, input int data_w, input int pc_w);
    return pc_w + data_w + addr_w;
  endfunction

  function automatic int ws_to_rf_bus_wd(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  localparam int BUS_W           = bus_w(5, 32, 32);
  localparam int WS_TO_RF_BUS_WD = ws_to_rf_bus_wd(5, 32);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant starting the scan at ptr
module rr_arbiter #(
  parameter int N    = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arb_stage.sv
// rtl/wb_arb_stage.sv - round-robin merge of producer results into one registered WB slot
module wb_arb_stage
  import mycpu_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*(1+ADDR_W+DATA_W+PC_W)-1:0] src_bus,
  input  logic                         ws_flush,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic                         ws_valid_o,
  output logic [ADDR_W-1:0]            ws_dest_o,
  output logic                         ws_we_o,
  output logic [DATA_W-1:0]            ws_fwd_data,
  output logic [PC_W-1:0]              debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_wen,
  output logic [ADDR_W-1:0]            debug_wb_rf_wnum,
  output logic [DATA_W-1:0]            debug_wb_rf_wdata,
  output logic [CNT_W-1:0]             retire_cnt
);

  localparam int SRC_BUS_W = bus_w(ADDR_W, DATA_W, PC_W);
  localparam int PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int RES_LSB   = result_lsb(PC_W);
  localparam int DST_LSB   = dest_lsb(DATA_W, PC_W);
  localparam int WE_POS    = we_bit(ADDR_W, DATA_W, PC_W);
  localparam int RF_BUS_W  = ws_to_rf_bus_wd(ADDR_W, DATA_W);

  logic [NUM_SRC-1:0]   gnt;
  logic                 grant;
  logic [PTR_W-1:0]     win_idx;
  logic [SRC_BUS_W-1:0] win_bus;

  logic                 ws_valid_q, ws_valid_d;
  logic [SRC_BUS_W-1:0] payload_q,  payload_d;
  logic [PTR_W-1:0]     rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;

  // Reset also masks the grant so producers never see an accept while the slot is held empty
  rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_arb (
    .req (src_valid),
    .en  (resetn & ~ws_flush),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign src_ready = gnt;
  assign grant     = |gnt;

  always_comb begin
    win_idx = '0;
    win_bus = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        win_idx = PTR_W'(i);
        win_bus = src_bus[i*SRC_BUS_W +: SRC_BUS_W];
      end
    end
  end

  always_comb begin
    ws_valid_d = grant;
    payload_d  = payload_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    if (grant) begin
      payload_d = win_bus;
      rr_ptr_d  = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + PTR_W'(1);
      cnt_d     = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      payload_q  <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      payload_q  <= payload_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  logic [ADDR_W-1:0]   ws_dest;
  logic [DATA_W-1:0]   ws_result;
  logic                ws_wr;
  logic [RF_BUS_W-1:0] ws_to_rf_bus;

  assign ws_dest      = payload_q[DST_LSB +: ADDR_W];
  assign ws_result    = payload_q[RES_LSB +: DATA_W];
  assign ws_wr        = ws_valid_q && payload_q[WE_POS] && (ws_dest != '0);
  assign ws_to_rf_bus = {ws_wr, ws_dest, ws_result};

  assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;
  assign ws_valid_o        = ws_valid_q;
  assign ws_dest_o         = ws_dest;
  assign ws_we_o           = ws_wr;
  assign ws_fwd_data       = ws_result;
  assign debug_wb_pc       = payload_q[pc_lsb() +: PC_W];
  assign debug_wb_rf_wen   = {4{ws_wr}};
  assign debug_wb_rf_wnum  = ws_dest;
  assign debug_wb_rf_wdata = ws_result;
  assign retire_cnt        = cnt_q;

endmodule

// File: tb/tb_wb_arb_stage.sv
// tb/tb_wb_arb_stage.sv - directed vector bench for wb_arb_stage
module tb_wb_arb_stage;

  localparam int BW = 70;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    src_valid;
  logic [2*BW-1:0] src_bus;
  logic          ws_flush;

  logic [1:0]  src_ready;
  logic        rf_we, ws_valid_o, ws_we_o;
  logic [4:0]  rf_waddr, ws_dest_o, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, ws_fwd_data, debug_wb_pc, debug_wb_rf_wdata, retire_cnt;
  logic [3:0]  debug_wb_rf_wen;

  logic [1:0]  src_ready4;
  logic        rf_we4, ws_valid_o4, ws_we_o4;
  logic [4:0]  rf_waddr4, ws_dest_o4, debug_wb_rf_wnum4;
  logic [31:0] rf_wdata4, ws_fwd_data4, debug_wb_pc4, debug_wb_rf_wdata4;
  logic [3:0]  debug_wb_rf_wen4;
  logic [3:0]  retire_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arb_stage dut (
    .clk(clk), .resetn(resetn), .src_valid(src_valid), .src_ready(src_ready),
    .src_bus(src_bus), .ws_flush(ws_flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ws_valid_o(ws_valid_o), .ws_dest_o(ws_dest_o),
    .ws_we_o(ws_we_o), .ws_fwd_data(ws_fwd_data), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .retire_cnt(retire_cnt)
  );

  wb_arb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .src_valid(src_valid), .src_ready(src_ready4),
    .src_bus(src_bus), .ws_flush(ws_flush), .rf_we(rf_we4), .rf_waddr(rf_waddr4),
    .rf_wdata(rf_wdata4), .ws_valid_o(ws_valid_o4), .ws_dest_o(ws_dest_o4),
    .ws_we_o(ws_we_o4), .ws_fwd_data(ws_fwd_data4), .debug_wb_pc(debug_wb_pc4),
    .debug_wb_rf_wen(debug_wb_rf_wen4), .debug_wb_rf_wnum(debug_wb_rf_wnum4),
    .debug_wb_rf_wdata(debug_wb_rf_wdata4), .retire_cnt(retire_cnt4)
  );

  typedef struct {
    logic [1:0]  v;
    logic        fl;
    logic        we0; logic [4:0] d0; logic [31:0] r0; logic [31:0] p0;
    logic        we1; logic [4:0] d1; logic [31:0] r1; logic [31:0] p1;
    logic [1:0]  rdy;
    logic        wsv;
    logic        rfwe;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [BW-1:0] pack(input logic we, input logic [4:0] d,
                                         input logic [31:0] r, input logic [31:0] p);
    return {we, d, r, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " src_ready"}, 64'(src_ready), 64'd0);
    chk({tag, " rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, " ws_valid_o"}, 64'(ws_valid_o), 64'd0);
    chk({tag, " rf_wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, " rf_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, " debug_wb_pc"}, 64'(debug_wb_pc), 64'd0);
    chk({tag, " debug_wen"}, 64'(debug_wb_rf_wen), 64'd0);
    chk({tag, " retire_cnt"}, 64'(retire_cnt), 64'd0);
    chk({tag, " retire_cnt4"}, 64'(retire_cnt4), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 0, 1, 5, 32'hDEADBEEF, 32'hBFC00000, 0, 0, 0, 0,
                 2'b01, 1, 1, 5, 32'hDEADBEEF, 32'hBFC00000, 1};
    vecs[1]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 2'b00, 0, 0, 5, 32'hDEADBEEF, 32'hBFC00000, 1};
    vecs[2]  = '{2'b11, 0, 1, 1, 32'hA0, 32'h100, 1, 2, 32'hB0, 32'h200,
                 2'b10, 1, 1, 2, 32'hB0, 32'h200, 2};
    vecs[3]  = '{2'b11, 0, 1, 1, 32'hA0, 32'h100, 1, 2, 32'hB0, 32'h200,
                 2'b01, 1, 1, 1, 32'hA0, 32'h100, 3};
    vecs[4]  = '{2'b11, 0, 1, 1, 32'hA0, 32'h100, 1, 2, 32'hB0, 32'h200,
                 2'b10, 1, 1, 2, 32'hB0, 32'h200, 4};
    vecs[5]  = '{2'b11, 0, 1, 1, 32'hA0, 32'h100, 1, 2, 32'hB0, 32'h200,
                 2'b01, 1, 1, 1, 32'hA0, 32'h100, 5};
    vecs[6]  = '{2'b01, 0, 1, 0, 32'h12345678, 32'h300, 0, 0, 0, 0,
                 2'b01, 1, 0, 0, 32'h12345678, 32'h300, 6};
    vecs[7]  = '{2'b11, 1, 1, 3, 32'hC0, 32'h400, 1, 4, 32'hD0, 32'h500,
                 2'b00, 0, 0, 0, 32'h12345678, 32'h300, 6};
    vecs[8]  = '{2'b11, 0, 1, 3, 32'hC0, 32'h400, 1, 4, 32'hD0, 32'h500,
                 2'b10, 1, 1, 4, 32'hD0, 32'h500, 7};
    vecs[9]  = '{2'b10, 0, 0, 0, 0, 0, 0, 7, 32'hE0, 32'h600,
                 2'b10, 1, 0, 7, 32'hE0, 32'h600, 8};
    vecs[10] = '{2'b01, 0, 1, 31, 32'hFFFFFFFF, 32'h700, 0, 0, 0, 0,
                 2'b01, 1, 1, 31, 32'hFFFFFFFF, 32'h700, 9};

    resetn    = 1'b0;
    src_valid = '0;
    src_bus   = '0;
    ws_flush  = 1'b0;
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) tick();
    chk_zero("idle");

    for (int k = 0; k < 11; k++) begin
      src_valid = vecs[k].v;
      ws_flush  = vecs[k].fl;
      src_bus   = {pack(vecs[k].we1, vecs[k].d1, vecs[k].r1, vecs[k].p1),
                   pack(vecs[k].we0, vecs[k].d0, vecs[k].r0, vecs[k].p0)};
      #1;
      chk($sformatf("v%0d src_ready", k), 64'(src_ready), 64'(vecs[k].rdy));
      tick();
      chk($sformatf("v%0d ws_valid_o", k), 64'(ws_valid_o), 64'(vecs[k].wsv));
      chk($sformatf("v%0d rf_we", k), 64'(rf_we), 64'(vecs[k].rfwe));
      chk($sformatf("v%0d ws_we_o", k), 64'(ws_we_o), 64'(vecs[k].rfwe));
      chk($sformatf("v%0d debug_wen", k), 64'(debug_wb_rf_wen), 64'({4{vecs[k].rfwe}}));
      chk($sformatf("v%0d rf_waddr", k), 64'(rf_waddr), 64'(vecs[k].dest));
      chk($sformatf("v%0d ws_dest_o", k), 64'(ws_dest_o), 64'(vecs[k].dest));
      chk($sformatf("v%0d debug_wnum", k), 64'(debug_wb_rf_wnum), 64'(vecs[k].dest));
      chk($sformatf("v%0d rf_wdata", k), 64'(rf_wdata), 64'(vecs[k].data));
      chk($sformatf("v%0d ws_fwd_data", k), 64'(ws_fwd_data), 64'(vecs[k].data));
      chk($sformatf("v%0d debug_wdata", k), 64'(debug_wb_rf_wdata), 64'(vecs[k].data));
      chk($sformatf("v%0d debug_pc", k), 64'(debug_wb_pc), 64'(vecs[k].pc));
      chk($sformatf("v%0d retire_cnt", k), 64'(retire_cnt), 64'(vecs[k].cnt));
      chk($sformatf("v%0d retire_cnt4", k), 64'(retire_cnt4), 64'(vecs[k].cnt[3:0]));
    end

    // Counter wrap: 17 back-to-back retires from channel 0 after a fresh reset
    src_valid = '0;
    ws_flush  = 1'b0;
    resetn    = 1'b0;
    tick();
    resetn    = 1'b1;
    tick();
    chk("wrap start cnt", 64'(retire_cnt), 64'd0);
    src_valid = 2'b01;
    src_bus   = {pack(0, 0, 0, 0), pack(1, 9, 32'h55AA55AA, 32'h800)};
    repeat (17) tick();
    chk("wrap retire_cnt", 64'(retire_cnt), 64'd17);
    chk("wrap retire_cnt4", 64'(retire_cnt4), 64'd1);
    chk("wrap rf_we", 64'(rf_we), 64'd1);
    chk("wrap rf_waddr", 64'(rf_waddr), 64'd9);

    // Asynchronous reset in the middle of a cycle, with channel 0 still requesting
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk_zero("async");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
